// File: rtl/id_redirect_pkg.sv
// id_redirect_pkg: opcode constants, widths and the decode helper shared by the decode stage.
package id_redirect_pkg;
  localparam int REG_W = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic uses_rt;
  } dec_t;

  function automatic dec_t decode(logic [31:0] instr);
    dec_t d;
    d.beq     = instr[31:26] == OP_BEQ;
    d.bne     = instr[31:26] == OP_BNE;
    d.j       = instr[31:26] == OP_J;
    d.jal     = instr[31:26] == OP_JAL;
    d.jr      = instr[31:26] == OP_RTYPE && instr[5:0] == FN_JR;
    // rt is a source for branches, stores and every R-type except jr
    d.uses_rt = d.beq || d.bne || instr[31:26] == OP_SW || (instr[31:26] == OP_RTYPE && !d.jr);
    return d;
  endfunction
endpackage

// File: rtl/id_redirect_hazard.sv
// id_hazard: combinational load-use / branch-operand stall detection and MEM forward selects.
module id_hazard
  import id_redirect_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  dec_t             dec,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [REG_W-1:0] WriteRegM,
  output logic             stall,
  output logic             fwd_a,
  output logic             fwd_b
);
  logic br, ex_a, ex_b, m_a, m_b, ld_use, ex_dep, m_dep;
  assign br     = dec.beq || dec.bne;
  assign ex_a   = WriteRegE != '0 && WriteRegE == rs;
  assign ex_b   = WriteRegE != '0 && WriteRegE == rt;
  assign m_a    = WriteRegM != '0 && WriteRegM == rs;
  assign m_b    = WriteRegM != '0 && WriteRegM == rt;
  assign ld_use = MemtoRegE && (ex_a || (dec.uses_rt && ex_b));
  assign ex_dep = (br || dec.jr) && RegWriteE && (ex_a || (br && ex_b));
  assign m_dep  = (br || dec.jr) && MemtoRegM && (m_a || (br && m_b));
  assign stall  = ld_use || ex_dep || m_dep;
  assign fwd_a  = RegWriteM && !MemtoRegM && m_a;
  assign fwd_b  = RegWriteM && !MemtoRegM && m_b;
endmodule

// File: rtl/id_redirect.sv
// id_redirect: IF/ID register, decode-stage branch/jump resolution, hazard stall and event counters.
module id_redirect
  import id_redirect_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [4:0]       WriteRegM,
  input  logic [31:0]      ALUOutM,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic [31:0]      PCBranchD,
  output logic [31:0]      JumpAddr,
  output logic             PCSrcD,
  output logic             JumpD,
  output logic             JalD,
  output logic             JrD,
  output logic             stall,
  output logic             FlushE,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  dec_t        dec;
  logic        fwd_a, fwd_b, redir;
  logic [31:0] src_a, src_b;
  logic [15:0] imm;

  assign dec   = decode(InstrD);
  assign imm   = InstrD[15:0];
  assign src_a = fwd_a ? ALUOutM : RD1D;
  assign src_b = fwd_b ? ALUOutM : RD2D;

  id_hazard u_hazard (
    .rs(InstrD[25:21]), .rt(InstrD[20:16]), .dec(dec),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  assign PCBranchD = PCPlus4D + {{14{imm[15]}}, imm, 2'b00};
  assign JumpAddr  = dec.jr ? src_a : {PCPlus4D[31:28], InstrD[25:0], 2'b00};
  assign PCSrcD    = ((dec.beq && src_a == src_b) || (dec.bne && src_a != src_b)) && !stall;
  assign JumpD     = dec.j && !stall;
  assign JalD      = dec.jal && !stall;
  assign JrD       = dec.jr && !stall;
  assign FlushE    = stall;
  assign redir     = PCSrcD || JumpD || JalD || JrD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD       <= NOP;
      PCPlus4D     <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (!stall) begin
        InstrD   <= (!DELAY_SLOT && redir) ? NOP : InstrF;
        PCPlus4D <= PCPlus4F;
      end
      if (redir && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_redirect.sv
// tb_id_redirect: random and directed checks of two id_redirect instances against a behavioural model.
module tb_id_redirect;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrF, PCPlus4F, RD1D, RD2D, ALUOutM;
  logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegE, WriteRegM;
  logic [31:0] instr_d1, pc4_d1, br1, ja1, rc1, sc1;
  logic [31:0] instr_d0, pc4_d0, br0, ja0;
  logic [3:0]  rc0, sc0;
  logic        pcsrc1, j1, jal1, jr1, stall1, flush1;
  logic        pcsrc0, j0, jal0, jr0, stall0, flush0;
  int          n_tests = 0, n_fail = 0;

  typedef struct packed {
    logic [31:0] br;
    logic [31:0] ja;
    logic pcsrc, j, jal, jr, stall;
  } exp_t;

  logic [31:0] m_instr[2], m_pc[2], m_rc[2], m_sc[2];

  always #5 clk = ~clk;

  id_redirect #(.DELAY_SLOT(1'b1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .RD1D(RD1D), .RD2D(RD2D),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .InstrD(instr_d1), .PCPlus4D(pc4_d1), .PCBranchD(br1), .JumpAddr(ja1),
    .PCSrcD(pcsrc1), .JumpD(j1), .JalD(jal1), .JrD(jr1), .stall(stall1), .FlushE(flush1),
    .redirect_cnt(rc1), .stall_cnt(sc1)
  );

  id_redirect #(.DELAY_SLOT(1'b0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .RD1D(RD1D), .RD2D(RD2D),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .InstrD(instr_d0), .PCPlus4D(pc4_d0), .PCBranchD(br0), .JumpAddr(ja0),
    .PCSrcD(pcsrc0), .JumpD(j0), .JalD(jal0), .JrD(jr0), .stall(stall0), .FlushE(flush0),
    .redirect_cnt(rc0), .stall_cnt(sc0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: evaluates the decode rules directly on an instruction word
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4);
    exp_t e;
    logic [5:0]  op = ins[31:26];
    logic [4:0]  rs = ins[25:21];
    logic [4:0]  rt = ins[20:16];
    logic [15:0] imm = ins[15:0];
    bit beq = op == 6'h04, bne = op == 6'h05, jmp = op == 6'h02, jal = op == 6'h03;
    bit jr = op == 6'h00 && ins[5:0] == 6'h08;
    bit rt_used = beq || bne || op == 6'h2b || (op == 6'h00 && !jr);
    bit ldu = MemtoRegE && WriteRegE != 0 && (WriteRegE == rs || (rt_used && WriteRegE == rt));
    bit exh = (beq || bne || jr) && RegWriteE && WriteRegE != 0 &&
              (WriteRegE == rs || ((beq || bne) && WriteRegE == rt));
    bit mh  = (beq || bne || jr) && MemtoRegM && WriteRegM != 0 &&
              (WriteRegM == rs || ((beq || bne) && WriteRegM == rt));
    bit fm  = RegWriteM && !MemtoRegM && WriteRegM != 0;
    logic [31:0] a = (fm && WriteRegM == rs) ? ALUOutM : RD1D;
    logic [31:0] b = (fm && WriteRegM == rt) ? ALUOutM : RD2D;
    e.stall = ldu || exh || mh;
    e.br    = pc4 + 32'($signed(imm)) * 4;
    e.ja    = jr ? a : ((pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 4));
    e.pcsrc = !e.stall && ((beq && a == b) || (bne && a != b));
    e.j     = !e.stall && jmp;
    e.jal   = !e.stall && jal;
    e.jr    = !e.stall && jr;
    return e;
  endfunction

  task automatic clear();
    InstrF = 0; PCPlus4F = 0; RD1D = 0; RD2D = 0; ALUOutM = 0;
    RegWriteE = 0; MemtoRegE = 0; WriteRegE = 0;
    RegWriteM = 0; MemtoRegM = 0; WriteRegM = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_instr[i] = 0; m_pc[i] = 0; m_rc[i] = 0; m_sc[i] = 0;
    end
  endtask

  // Called at a negedge with inputs driven; checks both instances then advances one cycle
  task automatic step();
    exp_t e[2];
    logic [31:0] mx;
    #1;
    for (int i = 0; i < 2; i++) e[i] = model(m_instr[i], m_pc[i]);
    check("u1.instr_d", instr_d1, m_instr[1]); check("u1.pc4_d", pc4_d1, m_pc[1]);
    check("u1.br", br1, e[1].br);              check("u1.ja", ja1, e[1].ja);
    check("u1.pcsrc", 32'(pcsrc1), 32'(e[1].pcsrc)); check("u1.j", 32'(j1), 32'(e[1].j));
    check("u1.jal", 32'(jal1), 32'(e[1].jal)); check("u1.jr", 32'(jr1), 32'(e[1].jr));
    check("u1.stall", 32'(stall1), 32'(e[1].stall)); check("u1.flush", 32'(flush1), 32'(e[1].stall));
    check("u1.rcnt", rc1, m_rc[1]);            check("u1.scnt", sc1, m_sc[1]);
    check("u0.instr_d", instr_d0, m_instr[0]); check("u0.pc4_d", pc4_d0, m_pc[0]);
    check("u0.br", br0, e[0].br);              check("u0.ja", ja0, e[0].ja);
    check("u0.pcsrc", 32'(pcsrc0), 32'(e[0].pcsrc)); check("u0.j", 32'(j0), 32'(e[0].j));
    check("u0.jal", 32'(jal0), 32'(e[0].jal)); check("u0.jr", 32'(jr0), 32'(e[0].jr));
    check("u0.stall", 32'(stall0), 32'(e[0].stall)); check("u0.flush", 32'(flush0), 32'(e[0].stall));
    check("u0.rcnt", 32'(rc0), m_rc[0]);       check("u0.scnt", 32'(sc0), m_sc[0]);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit any = e[i].pcsrc || e[i].j || e[i].jal || e[i].jr;
      mx = (i == 0) ? 32'd15 : 32'hFFFF_FFFF;
      if (!e[i].stall) begin
        m_instr[i] = (i == 0 && any) ? 32'h0 : InstrF;
        m_pc[i] = PCPlus4F;
      end
      if (any && m_rc[i] != mx) m_rc[i]++;
      if (e[i].stall && m_sc[i] != mx) m_sc[i]++;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[8] = '{6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h00, 6'h23, 6'h2b};
    logic [31:0] w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    if (w[31:26] == 6'h00) w[5:0] = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'h20;
    return w;
  endfunction

  task automatic rand_inputs();
    InstrF = rand_instr(); PCPlus4F = $urandom;
    RD1D = 32'($urandom_range(0, 1)); RD2D = 32'($urandom_range(0, 1)); ALUOutM = 32'($urandom_range(0, 1));
    RegWriteE = 1'($urandom_range(0, 3) == 0); MemtoRegE = 1'($urandom_range(0, 3) == 0);
    WriteRegE = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom_range(0, 1)); MemtoRegM = 1'($urandom_range(0, 3) == 0);
    WriteRegM = 5'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1;
    clear();
    #2 rst = 1'b0;
    #1;
    check("rst.instr_d", instr_d1, 0); check("rst.stall", 32'(stall1), 0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin rand_inputs(); step(); end
    // Mid-stream asynchronous reset
    #2 rst = 1'b0; clear(); InstrF = 32'h1000_0003;
    #1;
    check("rst.instr_d", instr_d1, 0); check("rst.pc4_d", pc4_d1, 0); check("rst.br", br1, 0);
    check("rst.stall", 32'(stall1), 0); check("rst.rcnt", rc1, 0); check("rst.scnt", sc1, 0);
    check("rst.u0.instr_d", instr_d0, 0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    // Taken beq, delay slot kept on u1 and flushed on u0
    clear(); InstrF = {6'h04, 5'd1, 5'd2, 16'd3}; PCPlus4F = 32'h40; step();
    InstrF = 32'h0000_0020; PCPlus4F = 32'h44; RD1D = 7; RD2D = 7;
    #1 check("beq.pcsrc", 32'(pcsrc1), 1); check("beq.target", br1, 32'h4C);
    step();
    check("beq.rcnt", rc1, 1); check("beq.slot_kept", instr_d1, 32'h0000_0020);
    check("beq.slot_flushed", instr_d0, 0);
    // bne resolved with forwarded ALUOutM
    clear(); InstrF = {6'h05, 5'd3, 5'd4, 16'hFFFF}; PCPlus4F = 32'h100; step();
    RD1D = 5; RD2D = 5; RegWriteM = 1; WriteRegM = 3; ALUOutM = 9;
    #1 check("bne.pcsrc", 32'(pcsrc1), 1); check("bne.target", br1, 32'hFC);
    step();
    // Load-use
    clear(); InstrF = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}; PCPlus4F = 32'h200; step();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; InstrF = 32'h1234_5678;
    #1 check("lu.stall", 32'(stall1), 1); check("lu.flush", 32'(flush1), 1);
    step();
    check("lu.hold", instr_d1, {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}); check("lu.scnt", sc1, 1);
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5;
    #1 check("lu.release", 32'(stall1), 0);
    step();
    // Branch waiting on a load: two stall cycles
    clear(); InstrF = {6'h04, 5'd2, 5'd0, 16'd4}; PCPlus4F = 32'h300; step();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2;
    #1 check("bl.stall1", 32'(stall1), 1);
    step();
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 2;
    #1 check("bl.stall2", 32'(stall1), 1); check("bl.nopcsrc", 32'(pcsrc1), 0);
    step();
    MemtoRegM = 0; RegWriteM = 0; WriteRegM = 0;
    #1 check("bl.stall3", 32'(stall1), 0); check("bl.pcsrc", 32'(pcsrc1), 1);
    check("bl.target", br1, 32'h310);
    step();
    // jal then jr
    clear(); InstrF = {6'h03, 26'h10}; PCPlus4F = 32'h8000_0010; step();
    InstrF = 32'h2222_0000; PCPlus4F = 32'h8000_0014;
    #1 check("jal.addr", ja1, 32'h8000_0040); check("jal.strobe", 32'(jal1), 1);
    check("jal.u0.strobe", 32'(jal0), 1);
    step();
    check("jal.slot_flushed", instr_d0, 0); check("jal.slot_kept", instr_d1, 32'h2222_0000);
    clear(); InstrF = {6'h00, 5'd31, 15'd0, 6'h08}; step();
    RD1D = 32'h100;
    #1 check("jr.strobe", 32'(jr1), 1); check("jr.addr", ja1, 32'h100);
    step();
    for (int k = 0; k < 400; k++) begin rand_inputs(); step(); end
    check("sat.u0.rcnt", 32'(rc0), 15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_redirect.md
# id_redirect

Decode-stage redirect and hazard unit for the 5-stage pipeline, the consumer end of the fetch interface. Holds the IF/ID pipeline register fed by the fetch stage's instruction and PC+4. Resolves beq/bne/j/jal/jr in decode and returns the branch target, the jump target, the select strobes and the stall signal to fetch. Also detects load-use and branch-operand hazards and keeps redirect and stall event counters.

## Interface
- DELAY_SLOT, 1: 1 keeps the instruction after a branch or jump (MIPS delay slot); 0 flushes it to a nop.
- CNT_W, 32: width of the saturating event counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrF  in  32  instruction from fetch.
- PCPlus4F  in  32  PC+4 from fetch.
- RD1D, RD2D  in  32  register-file read data for rs and rt of InstrD.
- RegWriteE, MemtoRegE  in  1  execute-stage write enable and load flag.
- WriteRegE  in  5  execute-stage destination register.
- RegWriteM, MemtoRegM  in  1  memory-stage write enable and load flag.
- WriteRegM  in  5  memory-stage destination register.
- ALUOutM  in  32  memory-stage ALU result, used for forwarding.
- InstrD, PCPlus4D  out  32  IF/ID register contents.
- PCBranchD, JumpAddr  out  32  branch target and jump target.
- PCSrcD, JumpD, JalD, JrD  out  1  redirect selects to fetch.
- stall  out  1  freezes the PC and the IF/ID register.
- FlushE  out  1  inserts a bubble into ID/EX.
- redirect_cnt, stall_cnt  out  CNT_W  event counters.

## Operation
- Decode from InstrD:
  - beq is op 6'h04; bne is op 6'h05.
  - j is op 6'h02; jal is op 6'h03.
  - jr is op 0 with funct 6'h08.
  - rs = InstrD[25:21]; rt = InstrD[20:16].
- Operand forwarding:
  - srcA = ALUOutM when RegWriteM, WriteRegM != 0, WriteRegM == rs and !MemtoRegM; otherwise srcA = RD1D.
  - srcB is formed the same way using rt and RD2D.
- stall is asserted when any of these holds:
  - Load-use: MemtoRegE, WriteRegE != 0, and WriteRegE equals rs, or rt for any instruction using rt.
  - Branch or jr reading a register being produced in EX: RegWriteE, WriteRegE != 0, WriteRegE == rs, or rt for branches.
  - Branch or jr reading a register being loaded in MEM: MemtoRegM, WriteRegM != 0, WriteRegM == rs, or rt for branches.
- FlushE = stall.
- Branch target: PCBranchD = PCPlus4D + ({{14{imm[15]}}, imm, 2'b00}), modulo 2^32, wrap-around allowed.
- Jump target: JumpAddr = srcA when jr; otherwise {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- Redirect strobes:
  - PCSrcD = (beq & srcA==srcB | bne & srcA!=srcB) & !stall.
  - JumpD, JalD and JrD are each the decoded flag & !stall.
  - With stall high, all redirects are suppressed: stall wins over redirect.
- IF/ID register update, in priority order:
  - stall: hold.
  - else, if DELAY_SLOT==0 and any redirect strobe is high: load InstrD = 32'h0 (nop) and PCPlus4D = PCPlus4F.
  - else: load InstrF and PCPlus4F.
- Counters:
  - redirect_cnt increments once per cycle in which any redirect strobe is high.
  - stall_cnt increments once per stall cycle.
  - Both saturate at all-ones.

## Timing
- Reset, asynchronous with rst low:
  - InstrD = 0, PCPlus4D = 0, counters = 0.
  - All derived outputs are therefore 0 while rst is low, including PCBranchD = 0 + 0 and stall = 0.
  - Reset mid-operation discards the in-flight instruction immediately.
- Latency:
  - InstrF captured at edge n appears on InstrD in cycle n+1.
  - Redirect outputs are combinational from InstrD and the forwarding inputs within that cycle.
  - Fetch loads the target at the next edge.
- Taken branch fetched at cycle t:
  - The delay-slot instruction is fetched at t+1.
  - The target is fetched at t+2.
  - With DELAY_SLOT=0, the delay slot reaches InstrD as a nop.
- A stall lasts one cycle per hazard. The load-use and MEM-load cases clear as the producer advances, so a branch waiting on a load stalls 2 cycles.
- A held InstrD re-evaluates every cycle; the redirect fires in the first cycle without stall.

## Structure
- Shared package holds:
  - opcode and funct constants: OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RTYPE, FN_JR;
  - the NOP constant;
  - the REG_W=5 width.
- One natural sub-module: id_hazard. It is purely combinational and takes rs/rt, the decoded flags and the EX/MEM controls, producing stall and the two forward selects.
- The IF/ID register and the counters stay in id_redirect.

## Test plan
- Reset: drive rst low mid-stream with InstrF=32'h1000_0003 → InstrD=0 and PCPlus4D=0 immediately, stall=0, counters=0.
- Taken beq: PCPlus4D=32'h40, InstrD=beq $1,$2,+3, RD1D=RD2D=7, no hazards → PCSrcD=1, PCBranchD=32'h4C, redirect_cnt becomes 1.
- bne with forwarding: InstrD=bne $3,$4,-1, RD1D=5, RD2D=5, RegWriteM=1, WriteRegM=3, ALUOutM=9 → PCSrcD=1, PCBranchD=PCPlus4D-4.
- Load-use: MemtoRegE=1, WriteRegE=5, InstrD=add $6,$5,$0 → stall=1 and FlushE=1 for 1 cycle; InstrD held; stall_cnt=1.
- Branch after load: lw $2 in EX, beq $2,$0 in D → stall for 2 cycles, then PCSrcD is evaluated using RD1D.
- jr/jal/flush: jal target 26'h10 with PCPlus4D=32'h8000_0010 → JumpAddr=32'h8000_0040, JalD=1; with DELAY_SLOT=0, InstrD becomes a nop on the next cycle. jr $31 with RD1D=32'h100 → JrD=1 and JumpAddr=32'h100.
